// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// optional first-word-fall-through read mode and overflow/underflow pulses.
module sync_fifo_prog #(
   parameter int G_WIDTH     = 8,
   parameter int G_DEPTH     = 16,
   parameter int G_FWFT      = 0,
   parameter int G_AF_THRESH = G_DEPTH - 2,
   parameter int G_AE_THRESH = 2
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_wr,
   input  logic [G_WIDTH-1:0]           i_data,
   input  logic                         i_rd,
   input  logic                         i_flush,
   output logic [G_WIDTH-1:0]           o_data,
   output logic                         o_valid,
   output logic                         o_full,
   output logic                         o_empty,
   output logic                         o_almost_full,
   output logic                         o_almost_empty,
   output logic [$clog2(G_DEPTH+1)-1:0] o_fill_level,
   output logic                         o_overflow,
   output logic                         o_underflow
);

   localparam int FILL_W = $clog2(G_DEPTH + 1);
   localparam int PTR_W  = $clog2(G_DEPTH);

   logic [G_WIDTH-1:0] mem [G_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [FILL_W-1:0]  fill;
   logic               wr_ok;
   logic               rd_ok;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(G_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A write into a full FIFO is only legal when a read frees a slot on the same edge;
   // a write never makes an empty FIFO readable in the same cycle.
   always_comb begin
      rd_ok = i_rd && !o_empty;
      wr_ok = i_wr && (!o_full || rd_ok);
   end

   assign o_fill_level   = fill;
   assign o_full         = (fill == FILL_W'(G_DEPTH));
   assign o_empty        = (fill == '0);
   assign o_almost_full  = (fill >= FILL_W'(G_AF_THRESH));
   assign o_almost_empty = (fill <= FILL_W'(G_AE_THRESH));

   always_ff @(posedge i_clk) begin
      if (!i_flush && wr_ok) begin
         mem[wr_ptr] <= i_data;
      end
   end

   // Flush wins over any request in the same cycle and suppresses the error pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill        <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else if (i_flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill        <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_overflow  <= i_wr && !wr_ok;
         o_underflow <= i_rd && !rd_ok;
         if (wr_ok) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (rd_ok) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({wr_ok, rd_ok})
            2'b10:   fill <= fill + FILL_W'(1);
            2'b01:   fill <= fill - FILL_W'(1);
            default: fill <= fill;
         endcase
      end
   end

   generate
      if (G_FWFT != 0) begin : g_fwft
         assign o_data  = mem[rd_ptr];
         assign o_valid = !o_empty;
      end else begin : g_std
         logic [G_WIDTH-1:0] data_q;
         logic               valid_q;

         // Registered read: o_data keeps its last value when no read is accepted.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               data_q  <= '0;
               valid_q <= 1'b0;
            end else if (i_flush) begin
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_ok;
               if (rd_ok) begin
                  data_q <= mem[rd_ptr];
               end
            end
         end

         assign o_data  = data_q;
         assign o_valid = valid_q;
      end
   endgenerate

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 The block SHALL have parameter G_WIDTH, default 8, data word width in bits (>=1).
REQ-002 The block SHALL have parameter G_DEPTH, default 16, storage depth in words (>=2, power of two not required).
REQ-003 The block SHALL have parameter G_FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 The block SHALL have parameter G_AF_THRESH, default G_DEPTH-2, almost-full threshold (1..G_DEPTH).
REQ-005 The block SHALL have parameter G_AE_THRESH, default 2, almost-empty threshold (0..G_DEPTH-1).
REQ-006 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-007 i_rst_n  in  1  asynchronous, active-low reset.
REQ-008 i_wr  in  1  write request.
REQ-009 i_data  in  G_WIDTH  write data.
REQ-010 i_rd  in  1  read request (pop).
REQ-011 i_flush  in  1  synchronous clear of contents.
REQ-012 o_data  out  G_WIDTH  read data.
REQ-013 o_valid  out  1  o_data holds a valid word.
REQ-014 o_full / o_empty  out  1 each  fill level == G_DEPTH / == 0.
REQ-015 o_almost_full / o_almost_empty  out  1 each  fill >= G_AF_THRESH / fill <= G_AE_THRESH.
REQ-016 o_fill_level  out  $clog2(G_DEPTH+1)  words currently stored.
REQ-017 o_overflow / o_underflow  out  1 each  one-cycle pulse on rejected write / rejected read.

Function
REQ-018 Write accepted when i_wr=1 and (not full, or full with accepted read same cycle); i_data stored at write pointer.
REQ-019 Read accepted when i_rd=1 and not empty; a write in the same cycle does not make an empty FIFO readable.
REQ-020 Pointers SHALL increment by one per accepted access and wrap from G_DEPTH-1 to 0.
REQ-021 Fill level: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds G_DEPTH or goes below 0.
REQ-022 o_full, o_empty, o_almost_full, o_almost_empty SHALL be decoded from the registered fill level, updating on the same edge as o_fill_level.
REQ-023 G_FWFT=0: accepted read at edge N drives head word on o_data with o_valid=1 after edge N (1-cycle latency); o_valid=0 after any edge with no accepted read; o_data holds last value.
REQ-024 G_FWFT=1: o_data SHALL equal the head word and o_valid = !o_empty continuously; accepted read advances to next word after the edge.
REQ-025 Rejected write (i_wr=1, not accepted) SHALL pulse o_overflow high for exactly the following cycle; storage unchanged.
REQ-026 Rejected read (i_rd=1, empty) SHALL pulse o_underflow high for exactly the following cycle; pointers unchanged.
REQ-027 i_flush=1 SHALL zero pointers and fill level at the edge, taking priority over i_wr/i_rd that cycle (both ignored, no overflow/underflow pulse); o_valid SHALL be 0 after the edge.
REQ-028 Storage contents need not be cleared by flush or reset.

Reset
REQ-029 i_rst_n=0 SHALL immediately, independent of i_clk, set pointers and fill to 0, o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0 (unless G_AF_THRESH=0 is disallowed, as it is), o_valid=0, o_overflow=0, o_underflow=0, o_data=0 (G_FWFT=0).
REQ-030 Reset asserted mid-transfer SHALL discard all stored words; first write after deassertion lands at address 0.
REQ-031 Requests in the cycle of reset deassertion SHALL be accepted normally at the next rising edge.

Verification
REQ-032 G_DEPTH=10, G_FWFT=0: write 1..10 -> o_full=1, fill=10, o_almost_full asserted from fill 8; 11th write -> o_overflow one-cycle pulse, fill stays 10.
REQ-033 G_FWFT=0: read 10 words -> o_data 1..10 each one cycle after i_rd with o_valid=1; extra read -> o_underflow pulse, o_valid=0.
REQ-034 G_DEPTH=10: 25 interleaved write/read of incrementing data -> pointer wrap 9->0, read order matches write order.
REQ-035 Full FIFO with i_wr=i_rd=1 -> both accepted, fill stays 10, no overflow; empty FIFO with both -> write accepted, underflow pulse, fill 1.
REQ-036 G_FWFT=1: write 0xA5 -> o_valid=1, o_data=0xA5 after edge without i_rd; i_rd -> o_empty=1, o_valid=0.
REQ-037 Fill 5, assert i_flush with i_wr=1 -> fill 0, o_empty=1, no write stored; repeat with i_rst_n pulsed low mid-cycle -> outputs reset before next clock edge.
